// File: rtl/store_buffer.sv
// Posted-write store queue between the core load/store path and data memory.
// Latency: stores retire in zero cycles, reach memory no earlier than the next cycle; loads pass through combinationally.
// Backpressure: stall on full queue, on a load overlapping a queued store, or on a fence while non-empty; drains wait on mem_ready.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [AW-1:0]              st_addr,
  input  logic [31:0]                st_data,
  input  logic [2:0]                 st_funct3,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_addr,
  input  logic [2:0]                 ld_funct3,
  input  logic                       fence_req,
  output logic                       stall,
  input  logic                       mem_ready,
  output logic                       mem_we,
  output logic [AW-1:0]              mem_addr,
  output logic [31:0]                mem_wd,
  output logic [2:0]                 mem_funct3,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [2:0]    funct3;
  } entry_t;

  entry_t            entries_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PW-1:0]     head_q;
  logic [PW-1:0]     tail_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              empty_q;

  logic              full;
  logic              hz;
  logic              ld_serve;
  logic              drain;
  logic              enq;
  logic [AW:0]       ld_lo;
  logic [AW:0]       ld_hi;
  logic [DEPTH-1:0]  hit;

  // Byte span of an access; ranges are one bit wider than the address so
  // a span ending past the top of memory never wraps back to zero.
  function automatic logic [AW:0] span(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   span = (AW+1)'(1);
      2'b01:   span = (AW+1)'(2);
      default: span = (AW+1)'(4);
    endcase
  endfunction

  assign ld_lo = {1'b0, ld_addr};
  assign ld_hi = ld_lo + span(ld_funct3) - (AW+1)'(1);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [AW:0] st_lo;
    logic [AW:0] st_hi;
    assign st_lo  = {1'b0, entries_q[i].addr};
    assign st_hi  = st_lo + span(entries_q[i].funct3) - (AW+1)'(1);
    assign hit[i] = valid_q[i] && (ld_lo <= st_hi) && (st_lo <= ld_hi);
  end

  assign hz       = |hit;
  assign full     = (count_q == CW'(DEPTH));
  assign ld_serve = ld_valid && !hz;
  assign drain    = !empty_q && mem_ready && !ld_serve;
  assign enq      = st_valid && !ld_valid && (!full || drain);

  assign stall = (ld_valid && hz) || (st_valid && !enq) || (fence_req && !empty_q);

  // Memory port mux: head entry while draining, otherwise the load address.
  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = ld_addr;
    mem_funct3 = ld_funct3;
    mem_wd     = 32'd0;
    if (drain) begin
      mem_we     = 1'b1;
      mem_addr   = entries_q[head_q].addr;
      mem_wd     = entries_q[head_q].data;
      mem_funct3 = entries_q[head_q].funct3;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry payload storage; validity is tracked separately so no reset needed here.
  always_ff @(posedge clk) begin
    if (enq) begin
      entries_q[tail_q] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
    end
  end

  // Pointers, valid bits and occupancy; reset discards every pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (drain) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      // Placed after the pop so a full-queue push into the freed slot wins.
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  assign count = count_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic [2:0]    st_funct3;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic [2:0]    ld_funct3;
  logic          fence_req;
  logic          stall;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wd;
  logic [2:0]    mem_funct3;
  logic [2:0]    count;
  logic          empty;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] exp_a [5];
  logic [31:0] exp_d [5];

  store_buffer #(.DEPTH(4), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .fence_req(fence_req), .stall(stall), .mem_ready(mem_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_funct3(mem_funct3),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  // Flag the illegal simultaneous load+store request whenever it is presented.
  always @(negedge clk) begin
    if (st_valid && ld_valid)
      $display("note: load and store presented together at %0t (load served, store held)", $time);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f3);
    ld_valid  = 1'b1;
    ld_addr   = a;
    ld_funct3 = f3;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 0; st_addr = 0; st_data = 0; st_funct3 = 0;
    ld_valid = 0; ld_addr = 0; ld_funct3 = 0; fence_req = 0; mem_ready = 0;
    exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single sw, drains the following cycle
    mem_ready = 1'b1;
    put(32'h100, 32'hDEADBEEF, 3'b010);
    #1;
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_no_bypass", 32'(mem_we), 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t1_count1", 32'(count), 32'd1);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_wd", mem_wd, 32'hDEADBEEF);
    chk("t1_f3", 32'(mem_funct3), 32'd2);
    tick();
    chk("t1_count0", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);

    // Fill to full, fifth store stalls, then push+pop together
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(exp_a[i], exp_d[i], 3'b010);
      tick();
    end
    chk("t2_full_count", 32'(count), 32'd4);
    put(exp_a[4], exp_d[4], 3'b010);
    #1;
    chk("t2_full_stall", 32'(stall), 32'd1);
    chk("t2_full_we", 32'(mem_we), 32'd0);
    tick();
    chk("t2_held_count", 32'(count), 32'd4);
    mem_ready = 1'b1;
    #1;
    chk("t2_accept_stall", 32'(stall), 32'd0);
    chk("t2_drain0_we", 32'(mem_we), 32'd1);
    chk("t2_drain0_addr", mem_addr, exp_a[0]);
    chk("t2_drain0_wd", mem_wd, exp_d[0]);
    tick();
    st_valid = 1'b0;
    #1;
    chk("t2_swap_count", 32'(count), 32'd4);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t2_drain%0d_we", i), 32'(mem_we), 32'd1);
      chk($sformatf("t2_drain%0d_addr", i), mem_addr, exp_a[i]);
      chk($sformatf("t2_drain%0d_wd", i), mem_wd, exp_d[i]);
      tick();
      chk($sformatf("t2_count%0d", i), 32'(count), 32'(4 - i));
    end
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_idle_we", 32'(mem_we), 32'd0);

    // Load overlapping a queued sb stalls until that byte drains
    mem_ready = 1'b0;
    put(32'h103, 32'hAB, 3'b000);
    tick();
    st_valid = 1'b0;
    load(32'h100, 3'b010);
    #1;
    chk("t3_hz_stall", 32'(stall), 32'd1);
    chk("t3_hz_we", 32'(mem_we), 32'd0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("t3_drain_we", 32'(mem_we), 32'd1);
    chk("t3_drain_addr", mem_addr, 32'h103);
    chk("t3_drain_wd", mem_wd, 32'hAB);
    chk("t3_drain_f3", 32'(mem_funct3), 32'd0);
    tick();
    chk("t3_ld_stall", 32'(stall), 32'd0);
    chk("t3_ld_addr", mem_addr, 32'h100);
    chk("t3_ld_f3", 32'(mem_funct3), 32'd2);
    chk("t3_ld_we", 32'(mem_we), 32'd0);
    ld_valid = 1'b0;

    // Misaligned sw 0x102 covers 0x102..0x105
    mem_ready = 1'b0;
    put(32'h102, 32'hCAFEF00D, 3'b010);
    tick();
    st_valid = 1'b0;
    load(32'h105, 3'b000);
    #1;
    chk("t4_lb105_stall", 32'(stall), 32'd1);
    load(32'h101, 3'b001);
    #1;
    chk("t4_lh101_stall", 32'(stall), 32'd1);
    load(32'h106, 3'b000);
    mem_ready = 1'b1;
    #1;
    chk("t4_lb106_stall", 32'(stall), 32'd0);
    chk("t4_lb106_addr", mem_addr, 32'h106);
    chk("t4_lb106_we", 32'(mem_we), 32'd0);
    tick();
    chk("t4_no_drain_count", 32'(count), 32'd1);
    ld_valid = 1'b0;
    tick();
    chk("t4_drained", 32'(count), 32'd0);

    // Top of address space: sw 0xFFFFFFFE does not wrap onto address 0
    mem_ready = 1'b0;
    put(32'hFFFFFFFE, 32'h12345678, 3'b010);
    tick();
    st_valid = 1'b0;
    load(32'h0, 3'b000);
    #1;
    chk("t5_nowrap_stall", 32'(stall), 32'd0);
    load(32'hFFFFFFFF, 3'b000);
    #1;
    chk("t5_top_stall", 32'(stall), 32'd1);
    ld_valid = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("t5_drained", 32'(count), 32'd0);

    // Fence holds the core until both queued stores have drained in order
    mem_ready = 1'b0;
    put(32'h200, 32'hA1, 3'b010);
    tick();
    put(32'h204, 32'hA2, 3'b010);
    tick();
    st_valid = 1'b0;
    chk("t6_count2", 32'(count), 32'd2);
    mem_ready = 1'b1;
    fence_req = 1'b1;
    #1;
    chk("t6_stall_a", 32'(stall), 32'd1);
    chk("t6_addr_a", mem_addr, 32'h200);
    tick();
    chk("t6_stall_b", 32'(stall), 32'd1);
    chk("t6_addr_b", mem_addr, 32'h204);
    chk("t6_wd_b", mem_wd, 32'hA2);
    tick();
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_release", 32'(stall), 32'd0);
    fence_req = 1'b0;

    // Illegal store+load together: load wins, store stalls and is not queued
    mem_ready = 1'b0;
    put(32'h300, 32'h99, 3'b010);
    load(32'h400, 3'b010);
    #1;
    chk("t7_stall", 32'(stall), 32'd1);
    chk("t7_addr", mem_addr, 32'h400);
    tick();
    chk("t7_count", 32'(count), 32'd0);
    st_valid = 1'b0;
    ld_valid = 1'b0;

    // Asynchronous reset mid-cycle discards pending stores
    for (int i = 0; i < 3; i++) begin
      put(32'h500 + 32'(4 * i), 32'hB0 + 32'(i), 3'b010);
      tick();
    end
    st_valid = 1'b0;
    chk("t8_count3", 32'(count), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t8_rst_count", 32'(count), 32'd0);
    chk("t8_rst_empty", 32'(empty), 32'd1);
    mem_ready = 1'b1;
    #1;
    chk("t8_rst_we", 32'(mem_we), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("t8_post_we%0d", i), 32'(mem_we), 32'd0);
      tick();
    end
    chk("t8_post_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
